// File: rtl/commit_trace_monitor.sv
// Run-control and commit-trace monitor: records the last DEPTH retired
// instructions and halts the run on a halt-PC commit, cycle budget or stall watchdog.
module commit_trace_monitor #(
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     DEPTH       = 16,
  parameter logic [PC_W-1:0] HALT_PC     = 'h400,
  parameter int unsigned     MAX_CYCLES  = 1000,
  parameter int unsigned     STALL_LIMIT = 64,
  parameter int unsigned     CNT_W       = 32,
  localparam int unsigned    AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic [4:0]       commit_rd,
  input  logic             commit_we,
  input  logic [PC_W-1:0]  commit_wdata,
  input  logic [AW-1:0]    trace_idx,
  output logic [PC_W-1:0]  trace_pc,
  output logic [31:0]      trace_inst,
  output logic [4:0]       trace_rd,
  output logic             trace_we,
  output logic [PC_W-1:0]  trace_wdata,
  output logic [AW:0]      trace_count,
  output logic             halt,
  output logic             freeze,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] commit_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] com_q;
  logic [CNT_W-1:0] idle_q;
  logic [1:0]       cause_q;

  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [31:0]      mem_inst  [DEPTH];
  logic [4:0]       mem_rd    [DEPTH];
  logic             mem_we    [DEPTH];
  logic [PC_W-1:0]  mem_wdata [DEPTH];

  logic [CNT_W-1:0] cyc_next;
  logic [CNT_W-1:0] idle_next;
  logic             pc_hit;
  logic             cyc_hit;
  logic             wd_hit;
  logic             accept;

  always_comb begin
    cyc_next  = cyc_q + CNT_W'(1);
    idle_next = commit_valid ? '0 : idle_q + CNT_W'(1);
    pc_hit    = commit_valid && (commit_pc == HALT_PC);
    cyc_hit   = (MAX_CYCLES != 0) && (cyc_next == CNT_W'(MAX_CYCLES));
    wd_hit    = (STALL_LIMIT != 0) && (idle_next == CNT_W'(STALL_LIMIT));
    accept    = (state == RUN) && !clear && commit_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      wr_ptr  <= '0;
      count_q <= '0;
      cyc_q   <= '0;
      com_q   <= '0;
      idle_q  <= '0;
      cause_q <= '0;
    end else if (clear) begin
      state   <= RUN;
      wr_ptr  <= '0;
      count_q <= '0;
      cyc_q   <= '0;
      com_q   <= '0;
      idle_q  <= '0;
      cause_q <= '0;
    end else if (state == RUN) begin
      cyc_q  <= cyc_next;
      idle_q <= idle_next;
      if (commit_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
        com_q  <= com_q + CNT_W'(1);
        if (count_q != (AW+1)'(DEPTH))
          count_q <= count_q + (AW+1)'(1);
      end
      // Priority order decides which single cause is recorded.
      if (pc_hit) begin
        state   <= HALTED;
        cause_q <= 2'd1;
      end else if (cyc_hit) begin
        state   <= HALTED;
        cause_q <= 2'd2;
      end else if (wd_hit) begin
        state   <= HALTED;
        cause_q <= 2'd3;
      end
    end
  end

  // Storage is not reset; trace_count masks stale entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_pc[wr_ptr]    <= commit_pc;
      mem_inst[wr_ptr]  <= commit_inst;
      mem_rd[wr_ptr]    <= commit_rd;
      mem_we[wr_ptr]    <= commit_we;
      mem_wdata[wr_ptr] <= commit_wdata;
    end
  end

  logic [AW-1:0] rd_ptr;
  logic          rd_ok;

  always_comb begin
    rd_ptr      = wr_ptr - count_q[AW-1:0] + trace_idx;
    rd_ok       = {1'b0, trace_idx} < count_q;
    trace_pc    = '0;
    trace_inst  = '0;
    trace_rd    = '0;
    trace_we    = 1'b0;
    trace_wdata = '0;
    if (rd_ok) begin
      trace_pc    = mem_pc[rd_ptr];
      trace_inst  = mem_inst[rd_ptr];
      trace_rd    = mem_rd[rd_ptr];
      trace_we    = mem_we[rd_ptr];
      trace_wdata = mem_wdata[rd_ptr];
    end
  end

  assign halt         = (state == HALTED);
  assign freeze       = halt;
  assign halt_cause   = cause_q;
  assign trace_count  = count_q;
  assign cycle_count  = cyc_q;
  assign commit_count = com_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Self-checking bench for commit_trace_monitor: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_commit_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic [4:0]  commit_rd;
  logic        commit_we;
  logic [31:0] commit_wdata;
  logic [3:0]  trace_idx;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic [4:0]  trace_rd;
  logic        trace_we;
  logic [31:0] trace_wdata;
  logic [4:0]  trace_count;
  logic        halt;
  logic        freeze;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [31:0] commit_count;

  commit_trace_monitor #(
    .PC_W(32), .DEPTH(16), .HALT_PC(32'h400),
    .MAX_CYCLES(1000), .STALL_LIMIT(64), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rd(commit_rd), .commit_we(commit_we), .commit_wdata(commit_wdata),
    .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_rd(trace_rd), .trace_we(trace_we), .trace_wdata(trace_wdata),
    .trace_count(trace_count), .halt(halt), .freeze(freeze), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: the trace is a queue of retired entries, oldest first.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } entry_t;

  entry_t      tq[$];
  logic [31:0] m_cyc, m_com, m_idle;
  logic        m_halted;
  logic [1:0]  m_cause;

  task automatic model_reset();
    tq.delete();
    m_cyc = 0; m_com = 0; m_idle = 0; m_halted = 0; m_cause = 0;
  endtask

  task automatic model_edge();
    entry_t e;
    if (clear) begin
      model_reset();
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1;
      if (commit_valid) begin
        e.pc = commit_pc; e.inst = commit_inst; e.rd = commit_rd;
        e.we = commit_we; e.wdata = commit_wdata;
        tq.push_back(e);
        if (tq.size() > 16) void'(tq.pop_front());
        m_com  = m_com + 1;
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
      end
      if (commit_valid && commit_pc == 32'h400) begin m_halted = 1; m_cause = 1; end
      else if (m_cyc == 1000)                   begin m_halted = 1; m_cause = 2; end
      else if (m_idle == 64)                    begin m_halted = 1; m_cause = 3; end
    end
  endtask

  task automatic compare_model();
    entry_t e;
    e = '{default: '0};
    if (int'(trace_idx) < tq.size()) e = tq[trace_idx];
    chk("halt",         halt,         m_halted);
    chk("freeze",       freeze,       m_halted);
    chk("halt_cause",   halt_cause,   m_cause);
    chk("cycle_count",  cycle_count,  m_cyc);
    chk("commit_count", commit_count, m_com);
    chk("trace_count",  trace_count,  tq.size());
    chk("trace_pc",     trace_pc,     e.pc);
    chk("trace_inst",   trace_inst,   e.inst);
    chk("trace_rd",     trace_rd,     e.rd);
    chk("trace_we",     trace_we,     e.we);
    chk("trace_wdata",  trace_wdata,  e.wdata);
  endtask

  task automatic cycle(input logic cv, input logic [31:0] pc, input logic clr, input logic [3:0] idx);
    commit_valid = cv;
    commit_pc    = pc;
    commit_inst  = $urandom;
    commit_rd    = 5'($urandom_range(0, 31));
    commit_we    = 1'($urandom_range(0, 1));
    commit_wdata = $urandom;
    clear        = clr;
    trace_idx    = idx;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic        clr;
    logic [3:0]  idx;
    logic        h;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] com;
    logic [4:0]  tc;
    logic [31:0] tpc;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [31:0] saved;

    vt[0] = '{1'b1, 32'h3F8, 1'b0, 4'd0, 1'b0, 2'd0, 32'd1, 32'd1, 5'd1, 32'h3F8};
    vt[1] = '{1'b1, 32'h3FC, 1'b0, 4'd1, 1'b0, 2'd0, 32'd2, 32'd2, 5'd2, 32'h3FC};
    vt[2] = '{1'b1, 32'h400, 1'b0, 4'd2, 1'b1, 2'd1, 32'd3, 32'd3, 5'd3, 32'h400};
    vt[3] = '{1'b1, 32'h500, 1'b0, 4'd3, 1'b1, 2'd1, 32'd3, 32'd3, 5'd3, 32'h0};
    vt[4] = '{1'b0, 32'h0,   1'b1, 4'd0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 32'h0};

    rst = 1'b1; clear = 0; commit_valid = 0; commit_pc = 0; commit_inst = 0;
    commit_rd = 0; commit_we = 0; commit_wdata = 0; trace_idx = 0;
    #12;
    rst = 1'b0;
    model_reset();
    #1;
    chk("reset_halt",  halt, 0);
    chk("reset_cause", halt_cause, 0);
    chk("reset_cyc",   cycle_count, 0);
    chk("reset_com",   commit_count, 0);
    chk("reset_tc",    trace_count, 0);
    chk("reset_tpc",   trace_pc, 0);

    // Halt-PC commit, ignored post-halt commit, then clear.
    foreach (vt[i]) begin
      cycle(vt[i].cv, vt[i].pc, vt[i].clr, vt[i].idx);
      chk("vec_halt",  halt,         vt[i].h);
      chk("vec_cause", halt_cause,   vt[i].cause);
      chk("vec_cyc",   cycle_count,  vt[i].cyc);
      chk("vec_com",   commit_count, vt[i].com);
      chk("vec_tc",    trace_count,  vt[i].tc);
      chk("vec_tpc",   trace_pc,     vt[i].tpc);
    end

    // Wrap-around of the trace buffer.
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i * 4), 1'b0, 4'(i % 16));
    chk("wrap_tc", trace_count, 16);
    trace_idx = 0;  #1; chk("wrap_idx0",  trace_pc, 32'h10);
    trace_idx = 15; #1; chk("wrap_idx15", trace_pc, 32'h4C);

    // Cycle budget.
    cycle(1'b0, 0, 1'b1, 0);
    for (int i = 1; i <= 1100 && !m_halted; i++)
      cycle(i % 8 == 0, 32'h1000 + 32'(i * 4), 1'b0, 4'($urandom_range(0, 15)));
    chk("budget_halt",  halt, 1);
    chk("budget_cause", halt_cause, 2);
    chk("budget_cyc",   cycle_count, 1000);
    saved = commit_count;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2000, 1'b0, 0);
    chk("budget_cyc_hold", cycle_count, 1000);
    chk("budget_com_hold", commit_count, saved);

    // PC match on the same edge as the cycle limit, then clear.
    cycle(1'b0, 0, 1'b1, 0);
    for (int i = 1; i <= 1000; i++)
      cycle(i % 8 == 0 || i == 1000, (i == 1000) ? 32'h400 : 32'h2000, 1'b0, 0);
    chk("tie_halt",  halt, 1);
    chk("tie_cause", halt_cause, 1);
    chk("tie_cyc",   cycle_count, 1000);
    cycle(1'b1, 32'h400, 1'b1, 0);
    chk("clear_halt", halt, 0);
    chk("clear_cyc",  cycle_count, 0);
    chk("clear_com",  commit_count, 0);
    chk("clear_tc",   trace_count, 0);

    // Stall watchdog.
    cycle(1'b1, 32'h3000, 1'b0, 0);
    for (int i = 0; i < 100 && !m_halted; i++) cycle(1'b0, 0, 1'b0, 0);
    chk("wd_halt",  halt, 1);
    chk("wd_cause", halt_cause, 3);
    chk("wd_cyc",   cycle_count, 65);
    cycle(1'b1, 32'h3004, 1'b0, 0);
    chk("wd_com_hold", commit_count, 1);
    chk("wd_tc_hold",  trace_count, 1);

    // Asynchronous reset while halted, between edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_halt",   halt, 0);
    chk("arst_freeze", freeze, 0);
    chk("arst_cause",  halt_cause, 0);
    chk("arst_cyc",    cycle_count, 0);
    chk("arst_com",    commit_count, 0);
    chk("arst_tc",     trace_count, 0);
    chk("arst_tpc",    trace_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with stall windows and occasional clears.
    for (int i = 0; i < 1600; i++) begin
      logic        cv;
      logic [31:0] pc;
      cv = (i % 400 >= 300 && i % 400 < 380) ? 1'b0 : ($urandom_range(0, 9) < 6);
      pc = ($urandom_range(0, 59) == 0) ? 32'h400 : ($urandom & 32'hFFFF_F3FC);
      cycle(cv, pc, $urandom_range(0, 99) == 0, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
